// File: rtl/eight_displays_pkg.sv
// Shared types and constants for the eight-digit BCD push-button counter.
package eight_displays_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int BCD_W      = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_t;

  function automatic bcd_t bcd_inc(input bcd_t d);
    return (d == BCD_MAX) ? bcd_t'(0) : bcd_t'(d + 4'd1);
  endfunction

endpackage

// File: rtl/eight_displays_debouncer.sv
// Button synchroniser plus debouncer: a level must persist DEBOUNCE_CYCLES
// synchronised cycles before it is accepted; press_o pulses on 1->0 acceptance.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic ck,
  input  logic reset,
  input  logic btn_i,
  output logic press_o,
  output logic stable_o
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_debouncer: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_deb
    $error("button_debouncer: DEBOUNCE_CYCLES must be 1..65535");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   s;
  logic                   accept;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      sync_q   <= '1;
      cnt_q    <= '0;
      stable_q <= 1'b1;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // Any return to the accepted level restarts the qualification window.
  assign accept = (s != stable_q) && (cnt_q == CNT_TC);

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (s == stable_q) begin
      cnt_d = '0;
    end else if (accept) begin
      stable_d = s;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Combinational so the counter advances on the same edge stable flips.
  assign press_o  = accept & ~s;
  assign stable_o = stable_q;

endmodule

// File: rtl/eight_displays.sv
// Debounced active-low push button driving an eight-digit BCD event counter,
// one digit per seven-segment display.
module eight_displays
  import eight_displays_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             add1,
  output logic [BCD_W-1:0] seg0,
  output logic [BCD_W-1:0] seg1,
  output logic [BCD_W-1:0] seg2,
  output logic [BCD_W-1:0] seg3,
  output logic [BCD_W-1:0] seg4,
  output logic [BCD_W-1:0] seg5,
  output logic [BCD_W-1:0] seg6,
  output logic [BCD_W-1:0] seg7
);

  logic                        press_w;
  logic                        stable_w;
  logic [NUM_DIGITS:0]         carry_w;
  logic [NUM_DIGITS*BCD_W-1:0] digits_w;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_debouncer (
    .ck      (ck),
    .reset   (reset),
    .btn_i   (add1),
    .press_o (press_w),
    .stable_o(stable_w)
  );

  // A press can only be accepted from the released level.
  assign carry_w[0] = press_w & stable_w;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_t dig_q;

    always_ff @(posedge ck or negedge reset) begin
      if (!reset) dig_q <= '0;
      else if (carry_w[g]) dig_q <= bcd_inc(dig_q);
    end

    assign carry_w[g+1]                 = carry_w[g] && (dig_q == BCD_MAX);
    assign digits_w[g*BCD_W +: BCD_W]   = dig_q;
  end

  assign seg0 = digits_w[0*BCD_W +: BCD_W];
  assign seg1 = digits_w[1*BCD_W +: BCD_W];
  assign seg2 = digits_w[2*BCD_W +: BCD_W];
  assign seg3 = digits_w[3*BCD_W +: BCD_W];
  assign seg4 = digits_w[4*BCD_W +: BCD_W];
  assign seg5 = digits_w[5*BCD_W +: BCD_W];
  assign seg6 = digits_w[6*BCD_W +: BCD_W];
  assign seg7 = digits_w[7*BCD_W +: BCD_W];

endmodule

// File: tb/tb_eight_displays.sv
// Bench for eight_displays: scoreboard of expected counter updates from a
// windowed-debounce reference model, checked by an independent output monitor.
module tb_eight_displays;

  localparam int DC = 4;
  localparam int SS = 2;

  logic       ck = 1'b0;
  logic       reset = 1'b0;
  logic       add1 = 1'b1;
  logic [3:0] seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
  logic [31:0] dut_val;

  eight_displays #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)) dut (
    .ck(ck), .reset(reset), .add1(add1),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .seg4(seg4), .seg5(seg5), .seg6(seg6), .seg7(seg7)
  );

  always #5 ck = ~ck;

  assign dut_val = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

  int checks = 0;
  int passes = 0;

  typedef struct {
    longint      edge_n;
    logic [31:0] val;
  } exp_t;
  exp_t   exp_q[$];
  longint edge_n = 0;

  // reference model state
  bit          line_q[$];
  bit          win_q[$];
  bit          m_stable;
  int unsigned m_count;

  function automatic logic [31:0] bcd_of(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    x = v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
  endtask

  task automatic model_reset();
    line_q.delete();
    for (int i = 0; i < SS; i++) line_q.push_back(1'b1);
    win_q.delete();
    m_stable = 1'b1;
    m_count  = 0;
    exp_q.delete();
  endtask

  // The level is accepted once DC consecutive synchronised samples all differ
  // from the currently accepted level; s lags the pin by SS sampling edges.
  task automatic model_step(input bit a);
    bit s_used;
    bit all_diff;
    s_used = line_q.pop_front();
    line_q.push_back(a);
    win_q.push_back(s_used);
    if (win_q.size() > DC) void'(win_q.pop_front());
    all_diff = (win_q.size() == DC);
    foreach (win_q[i]) if (win_q[i] == m_stable) all_diff = 1'b0;
    if (all_diff) begin
      m_stable = ~m_stable;
      win_q.delete();
      if (m_stable == 1'b0) begin
        exp_t e;
        m_count  = (m_count + 1) % 100000000;
        e.edge_n = edge_n;
        e.val    = bcd_of(m_count);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic tick(input bit a);
    add1 = a;
    @(posedge ck);
    edge_n++;
    model_step(a);
    #1;
  endtask

  task automatic do_reset(input int n, input bit a);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      add1 = a;
      @(posedge ck);
      edge_n++;
      #1;
      chk("reset_hold", dut_val, 0);
    end
    reset = 1'b1;
  endtask

  task automatic press(input int lo, input int hi);
    repeat (lo) tick(1'b0);
    repeat (hi) tick(1'b1);
  endtask

  // Monitor: every visible output change must match the next expected update.
  logic [31:0] last_seen = '0;
  always @(negedge ck) begin
    if (reset) begin
      if (dut_val != last_seen) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_update", dut_val, last_seen);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("update_value", dut_val, e.val);
          chk("update_edge", edge_n, e.edge_n);
        end
      end
      if (exp_q.size() > 0 && exp_q[0].edge_n < edge_n) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("missed_update", dut_val, e.val);
      end
    end
    last_seen = dut_val;
  end

  initial begin
    #1;
    do_reset(5, 1'b1);
    repeat (100) tick(1'b1);
    chk("idle_after_reset", dut_val, 0);

    press(10, 10);
    chk("single_press", dut_val, 32'h1);

    press(3, 10);
    chk("glitch_3", dut_val, 32'h1);
    press(2, 1);
    press(2, 10);
    chk("glitch_split", dut_val, 32'h1);

    repeat (9) press(10, 10);
    chk("carry_10", dut_val, 32'h10);
    repeat (990) press(10, 10);
    chk("carry_1000", dut_val, 32'h1000);

    press(500, 10);
    chk("long_hold", dut_val, 32'h1001);
    press(10, 10);
    chk("after_hold", dut_val, 32'h1002);

    // reset asserted two cycles into a press, released with the pin still low
    tick(1'b0);
    tick(1'b0);
    do_reset(3, 1'b0);
    tick(1'b0);
    repeat (10) tick(1'b1);
    chk("reset_mid_debounce", dut_val, 0);
    press(10, 10);
    chk("press_after_reset", dut_val, 32'h1);

    for (int i = 0; i < 400; i++) begin
      int unsigned lo, hi;
      lo = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 40) : $urandom_range(1, 8);
      hi = $urandom_range(1, 8);
      press(int'(lo), int'(hi));
    end
    repeat (20) tick(1'b1);
    chk("random_total", dut_val, bcd_of(m_count));
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
